// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD types, limits and serial-adder state encoding
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } bcd_ser_state_t;

endpackage

// File: rtl/bcd_adder.sv
// rtl/bcd_adder.sv - single-digit BCD adder with decimal correction
module bcd_adder
  import bcd_pkg::*;
(
  input  bcd_t a,
  input  bcd_t b,
  input  logic cin,
  output bcd_t s,
  output logic cout
);

  logic [4:0] bin_sum;
  logic [4:0] adj_sum;

  // Binary add, then add 6 whenever the raw result leaves the decimal range.
  always_comb begin
    bin_sum = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    adj_sum = bin_sum + 5'd6;
    cout    = (bin_sum > {1'b0, BCD_MAX});
    s       = cout ? adj_sum[3:0] : bin_sum[3:0];
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - digit-serial multi-digit BCD adder controller
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  bcd_t [DIGITS-1:0] a,
  input  bcd_t [DIGITS-1:0] b,
  input  logic              cin,
  output logic              busy,
  output logic              done,
  output bcd_t [DIGITS-1:0] sum,
  output logic              cout,
  output logic              err
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  bcd_ser_state_t    state_q, state_d;
  bcd_t [DIGITS-1:0] a_q, a_d;
  bcd_t [DIGITS-1:0] b_q, b_d;
  bcd_t [DIGITS-1:0] sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              err_q, err_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  bcd_t dig_a;
  bcd_t dig_b;
  bcd_t add_s;
  logic add_c;
  logic bad_digit;

  // The single shared digit adder, fed from the captured operands at idx.
  assign dig_a = a_q[idx_q];
  assign dig_b = b_q[idx_q];

  bcd_adder u_bcd_adder (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_c)
  );

  // Flag any non-decimal digit on the live operands, used only at capture.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[i] > BCD_MAX || b[i] > BCD_MAX) begin
        bad_digit = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath updates; an errored run keeps its length but writes zeros.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    err_d   = err_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          err_d   = bad_digit;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[idx_q] = err_q ? 4'd0 : add_s;
        carry_d      = add_c;
        idx_d        = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = err_q ? 1'b0 : add_c;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand, result and sequencing registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule
